fft_butterfly_r2: RTL
=====================

FFT_BUTTERFLY_R2 -- requirements
Module: fft_butterfly_r2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed fixed-point component width.
REQ-002 SHALL have parameter FRAC_BITS, default 16, fractional bits (Q16.16 at defaults).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input operand set valid.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 a_re, a_im  input  DATA_WIDTH each  signed operand A.
REQ-008 b_re, b_im  input  DATA_WIDTH each  signed operand B.
REQ-009 w_re, w_im  input  DATA_WIDTH each  signed twiddle W.
REQ-010 out_valid  output  1  result pair valid.
REQ-011 out_ready  input  1  downstream accepts result pair.
REQ-012 x_re, x_im  output  DATA_WIDTH each  X = A + B*W.
REQ-013 y_re, y_im  output  DATA_WIDTH each  Y = A - B*W.

Function
REQ-014 Transfer on an interface SHALL occur only in a cycle where valid and ready are both high.
REQ-015 SHALL be a 3-stage pipeline: S1 registers A, B, W; S2 forms the product P = B*W and carries A; S3 forms X and Y.
REQ-016 Latency SHALL be 3 cycles, accept edge to out_valid high, when out_ready is held high.
REQ-017 Throughput SHALL be one operand set per cycle with out_ready continuously high.
REQ-018 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or its contents move downstream in the same cycle.
REQ-019 in_ready SHALL equal (S1 empty) OR (S1 advances this cycle); it is combinational from out_ready through the stage chain.
REQ-020 While out_valid is high and out_ready is low, x/y outputs SHALL remain stable.
REQ-021 Products SHALL sign-extend operands to 2*DATA_WIDTH and form P_re = (br*wr - bi*wi) >>> FRAC_BITS, P_im = (br*wi + bi*wr) >>> FRAC_BITS, as arithmetic shifts (round toward minus infinity).
REQ-022 Without the Configuration macro, P SHALL be truncated to the low DATA_WIDTH bits, and X/Y SHALL be DATA_WIDTH two's-complement wrapping add/sub.
REQ-023 Operand sets SHALL leave the block in the order accepted, with none lost or duplicated.
REQ-024 With the pipeline full and out_ready low, in_ready SHALL be low; when out_ready then goes high, output and input transfers SHALL occur in that same cycle.

Reset
REQ-025 While rst_n is low, all stage valid bits and out_valid SHALL be 0, and all data registers and x/y outputs SHALL be 0.
REQ-026 Reset assertion mid-operation SHALL discard all in-flight sets immediately; none SHALL emerge after release.
REQ-027 in_ready SHALL be high from the first cycle after reset release.

Configuration
REQ-028 Macro FFT_BFLY_SATURATE_EN, when defined, SHALL clamp P and X/Y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] when the result is out of range, instead of wrapping.
REQ-029 With FFT_BFLY_SATURATE_EN undefined, behaviour SHALL be REQ-022 wrapping; latency and handshake SHALL be identical in both builds.

Verification
REQ-030 A=(0x00010000,0), B=(0x00010000,0), W=(0x00010000,0) -> X=(0x00020000,0), Y=(0,0), out_valid 3 cycles after accept.
REQ-031 A=(0,0), B=(0x00010000,0), W=(0,0xFFFF0000) -> X=(0,0xFFFF0000), Y=(0,0x00010000).
REQ-032 out_ready low, 5 back-to-back sets offered -> exactly 3 accepted and then in_ready low; release out_ready -> all 5 sets exit in order, one per cycle.
REQ-033 A=(0x7FFF0000,0), B=(0x00010000,0), W=(0x00010000,0) -> X_re=0x80000000 without the macro, 0x7FFFFFFF with FFT_BFLY_SATURATE_EN.
REQ-034 Pulse rst_n low for 1 cycle with 2 sets in flight -> out_valid stays 0 and no stale output follows; the next accepted set produces the correct result.
REQ-035 Random in_valid/out_ready toggling over 1000 sets, checked against a reference model -> all results match, in order, with no output change while stalled.

Source files
------------

// File: rtl/fft_butterfly_r2.sv
// Radix-2 decimation-in-time butterfly: X = A + B*W, Y = A - B*W.
// Three-stage valid/ready pipeline on signed fixed-point complex operands.
// Optional build macro FFT_BFLY_SATURATE_EN clamps the product and the
// X/Y sums to the signed DATA_WIDTH range; without it they wrap.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Each stage loads when it is empty or its content moves on in
// the same cycle, so in_ready is a combinational function of out_ready
// through the stage valid bits.
module fft_butterfly_r2 #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_re,
  input  logic [DATA_WIDTH-1:0] a_im,
  input  logic [DATA_WIDTH-1:0] b_re,
  input  logic [DATA_WIDTH-1:0] b_im,
  input  logic [DATA_WIDTH-1:0] w_re,
  input  logic [DATA_WIDTH-1:0] w_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x_re,
  output logic [DATA_WIDTH-1:0] x_im,
  output logic [DATA_WIDTH-1:0] y_re,
  output logic [DATA_WIDTH-1:0] y_im
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;

  // Stage 1: registered operands
  logic                s1_valid;
  logic signed [W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s1_w_re, s1_w_im;
  // Stage 2: product and delayed A
  logic                s2_valid;
  logic signed [W-1:0] s2_a_re, s2_a_im, s2_p_re, s2_p_im;
  // Stage 3: butterfly outputs
  logic                s3_valid;
  logic signed [W-1:0] s3_x_re, s3_x_im, s3_y_re, s3_y_im;

  // A stage may load when it is empty or its content leaves this cycle
  logic s1_ready, s2_ready, s3_ready;
  assign s3_ready = !s3_valid || out_ready;
  assign s2_ready = !s2_valid || s3_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  // Full-width complex product B*W, scaled back by FRAC_BITS (floor shift)
  logic signed [W2-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [W2-1:0] p_re_full, p_im_full;
  logic signed [W-1:0]  p_re, p_im;
  logic signed [W-1:0]  x_re_n, x_im_n, y_re_n, y_im_n;

  assign br_x = {{W{s1_b_re[W-1]}}, s1_b_re};
  assign bi_x = {{W{s1_b_im[W-1]}}, s1_b_im};
  assign wr_x = {{W{s1_w_re[W-1]}}, s1_w_re};
  assign wi_x = {{W{s1_w_im[W-1]}}, s1_w_im};
  assign p_re_full = (br_x * wr_x - bi_x * wi_x) >>> FRAC_BITS;
  assign p_im_full = (br_x * wi_x + bi_x * wr_x) >>> FRAC_BITS;

`ifdef FFT_BFLY_SATURATE_EN
  // Clamp a double-width value into the signed W-bit range
  function automatic logic [W-1:0] sat_p(input logic [W2-1:0] v);
    if ((&v[W2-1:W-1]) || !(|v[W2-1:W-1])) return v[W-1:0];
    else if (v[W2-1]) return {1'b1, {(W-1){1'b0}}};
    else return {1'b0, {(W-1){1'b1}}};
  endfunction

  // Clamp a (W+1)-bit sum into the signed W-bit range
  function automatic logic [W-1:0] sat_s(input logic [W:0] v);
    if (v[W] == v[W-1]) return v[W-1:0];
    else if (v[W]) return {1'b1, {(W-1){1'b0}}};
    else return {1'b0, {(W-1){1'b1}}};
  endfunction

  logic signed [W:0] xr_sum, xi_sum, yr_dif, yi_dif;
  assign xr_sum = {s2_a_re[W-1], s2_a_re} + {s2_p_re[W-1], s2_p_re};
  assign xi_sum = {s2_a_im[W-1], s2_a_im} + {s2_p_im[W-1], s2_p_im};
  assign yr_dif = {s2_a_re[W-1], s2_a_re} - {s2_p_re[W-1], s2_p_re};
  assign yi_dif = {s2_a_im[W-1], s2_a_im} - {s2_p_im[W-1], s2_p_im};

  assign p_re   = sat_p(p_re_full);
  assign p_im   = sat_p(p_im_full);
  assign x_re_n = sat_s(xr_sum);
  assign x_im_n = sat_s(xi_sum);
  assign y_re_n = sat_s(yr_dif);
  assign y_im_n = sat_s(yi_dif);
`else
  // Wrapping arithmetic: upper product bits are intentionally discarded
  logic unused_p_hi;
  assign unused_p_hi = ^{p_re_full[W2-1:W], p_im_full[W2-1:W]};

  assign p_re   = p_re_full[W-1:0];
  assign p_im   = p_im_full[W-1:0];
  assign x_re_n = s2_a_re + s2_p_re;
  assign x_im_n = s2_a_im + s2_p_im;
  assign y_re_n = s2_a_re - s2_p_re;
  assign y_im_n = s2_a_im - s2_p_im;
`endif

  // Stage 1: capture operands on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a_re <= a_re;
        s1_a_im <= a_im;
        s1_b_re <= b_re;
        s1_b_im <= b_im;
        s1_w_re <= w_re;
        s1_w_im <= w_im;
      end
    end
  end

  // Stage 2: register the scaled product and carry A alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      s2_p_re  <= '0;
      s2_p_im  <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a_re <= s1_a_re;
        s2_a_im <= s1_a_im;
        s2_p_re <= p_re;
        s2_p_im <= p_im;
      end
    end
  end

  // Stage 3: register X and Y; held unchanged while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_x_re  <= '0;
      s3_x_im  <= '0;
      s3_y_re  <= '0;
      s3_y_im  <= '0;
    end else if (s3_ready) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_x_re <= x_re_n;
        s3_x_im <= x_im_n;
        s3_y_re <= y_re_n;
        s3_y_im <= y_im_n;
      end
    end
  end

  assign out_valid = s3_valid;
  assign x_re      = s3_x_re;
  assign x_im      = s3_x_im;
  assign y_re      = s3_y_re;
  assign y_im      = s3_y_im;

endmodule
